// File: rtl/mem_port_arbiter.sv
// Shares the single unified RAM port between fetch (IF) and load/store (MEM).
// At most one read in flight; MEM has priority, bounded by an IF starvation counter.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk_50,
   input  logic          rst,

   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,

   input  logic          mem_req,
   input  logic          mem_we,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic          mem_gnt,
   output logic          mem_rvalid,
   output logic [DW-1:0] mem_rdata,

   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,

   output logic          busy
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   localparam logic OwnIf  = 1'b0;
   localparam logic OwnMem = 1'b1;

   state_e     state_q, state_d;
   logic [3:0] lat_cnt_q, lat_cnt_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       owner_q, owner_d;

   logic resp_cycle;
   logic can_arb;
   logic starve_hit;
   logic if_win;
   logic mem_win;
   logic read_gnt;

   // Final WAIT cycle doubles as an arbitration slot for back-to-back reads.
   assign resp_cycle = (state_q == StWait) && (lat_cnt_q == 4'd0);
   assign can_arb    = !rst && ((state_q == StIdle) || resp_cycle);
   assign starve_hit = (starve_cnt_q == 4'(STARVE_MAX));
   assign if_win     = can_arb && if_req && (!mem_req || starve_hit);
   assign mem_win    = can_arb && mem_req && !if_win;
   assign read_gnt   = if_win || (mem_win && !mem_we);

   always_comb begin
      if_gnt     = if_win;
      mem_gnt    = mem_win;
      ram_en     = if_win || mem_win;
      ram_we     = mem_win && mem_we;
      ram_addr   = '0;
      ram_wdata  = '0;
      if (mem_win) begin
         ram_addr  = mem_addr;
         ram_wdata = mem_wdata;
      end else if (if_win) begin
         ram_addr  = if_addr;
      end

      // Response is a combinational pass-through of the RAM read data.
      if_rvalid  = !rst && resp_cycle && (owner_q == OwnIf);
      mem_rvalid = !rst && resp_cycle && (owner_q == OwnMem);
      if_rdata   = if_rvalid  ? ram_rdata : '0;
      mem_rdata  = mem_rvalid ? ram_rdata : '0;

      busy       = !rst && (state_q == StWait);
   end

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;

      if (read_gnt) begin
         state_d   = StWait;
         lat_cnt_d = 4'(MEM_LAT - 1);
         owner_d   = mem_win ? OwnMem : OwnIf;
      end else if (state_q == StWait) begin
         if (lat_cnt_q == 4'd0) begin
            state_d = StIdle;
         end else begin
            lat_cnt_d = lat_cnt_q - 4'd1;
         end
      end

      if (if_win || !if_req) begin
         starve_cnt_d = 4'd0;
      end else if (mem_win && !starve_hit) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         state_q      <= StIdle;
         lat_cnt_q    <= 4'd0;
         starve_cnt_q <= 4'd0;
         owner_q      <= OwnIf;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         owner_q      <= owner_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT = 2, STARVE_MAX = 4).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_port_arbiter;

   logic        clk_50 = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        busy;

   int n_total = 0;
   int n_bad   = 0;

   always #10 clk_50 = ~clk_50;

   mem_port_arbiter #(
      .AW         (32),
      .DW         (32),
      .MEM_LAT    (2),
      .STARVE_MAX (4)
   ) dut (
      .clk_50     (clk_50),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle: through the rising edge to the next falling edge.
   task automatic tick();
      @(posedge clk_50);
      @(negedge clk_50);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      if_req    = 1'b1;
      if_addr   = 32'h0;
      mem_req   = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = 32'h100;
      mem_wdata = 32'h0;
      ram_rdata = 32'h0;

      // Reset held two cycles with both requests high.
      @(negedge clk_50);
      for (int c = 0; c < 2; c++) begin
         settle();
         check("rst_if_gnt",  if_gnt,  0);
         check("rst_mem_gnt", mem_gnt, 0);
         check("rst_ram_en",  ram_en,  0);
         check("rst_busy",    busy,    0);
         check("rst_rvalid",  {if_rvalid, mem_rvalid}, 0);
         check("rst_addr",    ram_addr, 0);
         tick();
      end

      // First cycle after release: MEM wins.
      rst = 1'b0;
      settle();
      check("rel_mem_gnt",  mem_gnt,  1);
      check("rel_if_gnt",   if_gnt,   0);
      check("rel_ram_en",   ram_en,   1);
      check("rel_ram_addr", ram_addr, 32'h100);
      tick();
      if_req  = 1'b0;
      mem_req = 1'b0;
      settle();
      check("rel_busy", busy, 1);
      tick();
      ram_rdata = 32'h1234;
      settle();
      check("rel_mem_rvalid", mem_rvalid, 1);
      check("rel_mem_rdata",  mem_rdata,  32'h1234);
      check("rel_if_rdata",   if_rdata,   0);
      tick();

      // Single IF read.
      if_req  = 1'b1;
      if_addr = 32'h10;
      settle();
      check("ifrd_gnt",  if_gnt,   1);
      check("ifrd_en",   ram_en,   1);
      check("ifrd_we",   ram_we,   0);
      check("ifrd_addr", ram_addr, 32'h10);
      tick();
      if_req = 1'b0;
      settle();
      check("ifrd_t1_busy",   busy,      1);
      check("ifrd_t1_rvalid", if_rvalid, 0);
      check("ifrd_t1_en",     ram_en,    0);
      tick();
      ram_rdata = 32'hDEADBEEF;
      settle();
      check("ifrd_rvalid",     if_rvalid,  1);
      check("ifrd_rdata",      if_rdata,   32'hDEADBEEF);
      check("ifrd_mem_rvalid", mem_rvalid, 0);
      check("ifrd_mem_rdata",  mem_rdata,  0);
      tick();
      settle();
      check("ifrd_idle_busy", busy, 0);

      // Back-to-back stores.
      mem_req = 1'b1;
      mem_we  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_addr  = 32'h20 + 32'(4 * i);
         mem_wdata = 32'hA000 + 32'(i);
         settle();
         check("st_gnt",   mem_gnt,   1);
         check("st_we",    ram_we,    1);
         check("st_addr",  ram_addr,  32'h20 + 32'(4 * i));
         check("st_wdata", ram_wdata, 32'hA000 + 32'(i));
         check("st_busy",  busy,      0);
         check("st_rv",    mem_rvalid, 0);
         tick();
      end
      mem_req = 1'b0;
      mem_we  = 1'b0;
      settle();
      check("st_done_en", ram_en, 0);

      // Starvation: IF held, MEM issues back-to-back loads.
      if_req    = 1'b1;
      if_addr   = 32'h40;
      mem_req   = 1'b1;
      mem_addr  = 32'h80;
      ram_rdata = 32'h5A5A0000;
      for (int k = 0; k <= 8; k++) begin
         settle();
         check("sv_mem_gnt",    mem_gnt,    ((k % 2 == 0) && k < 8) ? 1 : 0);
         check("sv_if_gnt",     if_gnt,     (k == 8) ? 1 : 0);
         check("sv_mem_rvalid", mem_rvalid, ((k % 2 == 0) && k > 0) ? 1 : 0);
         check("sv_busy",       busy,       (k > 0) ? 1 : 0);
         if (k == 8) check("sv_if_addr", ram_addr, 32'h40);
         tick();
      end
      // IF response cycle: starvation count was cleared, so MEM wins again.
      settle();
      check("sv_k9_busy", busy, 1);
      tick();
      ram_rdata = 32'hC0DE0001;
      settle();
      check("sv_if_rvalid",  if_rvalid, 1);
      check("sv_if_rdata",   if_rdata,  32'hC0DE0001);
      check("sv_cleared_mg", mem_gnt,   1);
      check("sv_cleared_ig", if_gnt,    0);
      tick();
      if_req  = 1'b0;
      mem_req = 1'b0;
      tick();
      ram_rdata = 32'h77;
      settle();
      check("sv_last_rvalid", mem_rvalid, 1);
      check("sv_last_rdata",  mem_rdata,  32'h77);
      check("sv_last_gnt",    {if_gnt, mem_gnt}, 0);
      tick();

      // Reset in the middle of an IF read.
      if_req  = 1'b1;
      if_addr = 32'h50;
      settle();
      check("rr_gnt", if_gnt, 1);
      tick();
      if_req = 1'b0;
      rst    = 1'b1;
      settle();
      check("rr_t1_gnt", if_gnt, 0);
      tick();
      rst       = 1'b0;
      ram_rdata = 32'h5555;
      settle();
      check("rr_t2_rvalid", if_rvalid, 0);
      check("rr_t2_rdata",  if_rdata,  0);
      check("rr_t2_busy",   busy,      0);
      tick();
      settle();
      check("rr_t3_busy",   busy,      0);
      check("rr_t3_rvalid", if_rvalid, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-port unified instruction/data RAM behind `pipeline_processor`. It shares the RAM port between the fetch stage (IF) and the memory stage (MEM) and keeps at most one transaction in flight. It counts the fixed RAM read latency and routes read data back to the requester that issued the read. MEM has priority; a starvation counter bounds how long fetch can be blocked.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MEM_LAT`, 2, cycles from RAM enable to valid `ram_rdata`; legal range 1..15.
- `STARVE_MAX`, 4, consecutive lost IF arbitrations before IF is forced to win; legal range 1..15.

Ports:
- `clk_50`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch read request, level.
- `if_addr`  in  AW  fetch address.
- `if_gnt`  out  1  one-cycle pulse: IF request accepted.
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid.
- `if_rdata`  out  DW  fetch read data.
- `mem_req`  in  1  load/store request, level.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  AW  load/store address.
- `mem_wdata`  in  DW  store data.
- `mem_gnt`  out  1  one-cycle pulse: MEM request accepted.
- `mem_rvalid`  out  1  one-cycle pulse: `mem_rdata` valid (loads only).
- `mem_rdata`  out  DW  load data.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  AW  RAM address.
- `ram_wdata`  out  DW  RAM write data.
- `ram_rdata`  in  DW  RAM read data, valid `MEM_LAT` cycles after `ram_en`.
- `busy`  out  1  a read is outstanding.

## Operation
- FSM states:
  - IDLE: no read outstanding.
  - WAIT: a read is outstanding; a latency counter runs.
- Requester contract:
  - `*_req`, address and data are held stable until the matching `*_gnt`.
  - A requester may drop `req` without a grant; the abandoned request is ignored.
- Arbitration is evaluated in IDLE, or in the last cycle of WAIT when the response is delivered:
  - Only one requester active: it wins.
  - Both active: MEM wins, unless `starve_cnt == STARVE_MAX`, in which case IF wins.
- Grant cycle:
  - `*_gnt` = 1 and `ram_en` = 1.
  - `ram_addr` and `ram_wdata` come from the winner.
  - `ram_we` = `mem_we` when MEM wins, 0 when IF wins.
  - All `ram_*` outputs are combinational from the winner.
  - `ram_we` = 0 and `ram_en` = 0 when there is no grant.
- Store grant: completes in the grant cycle. FSM stays in IDLE, no rvalid is produced.
- Read grant:
  - FSM goes to WAIT.
  - `lat_cnt` loads `MEM_LAT - 1`.
  - An `owner` flag (IF/MEM) is registered.
- WAIT:
  - `lat_cnt` decrements each cycle.
  - When `lat_cnt == 0`: the owner's `*_rvalid` = 1 and its `*_rdata` = `ram_rdata`. This is combinational pass-through, the non-owner's rdata is 0.
  - In that same cycle a new grant may issue (back-to-back). Otherwise the FSM returns to IDLE.
- MEM_LAT = 1: the rvalid cycle is the cycle after the grant.
- `starve_cnt`:
  - Increments, saturating at `STARVE_MAX`, in each cycle where `if_req` = 1 and MEM is granted.
  - Clears when IF is granted or `if_req` = 0.
  - Holds otherwise.
- `busy` = 1 in WAIT.

## Timing
- Reset values: all outputs 0; FSM = IDLE; `lat_cnt` = 0; `starve_cnt` = 0; `owner` = IF.
- `rst` mid-transaction: the outstanding read is dropped. No rvalid is produced for it, and no grant is given in the cycle `rst` is high.
- Grant latency: same cycle as `req` when the FSM is idle.
- Read response: rvalid exactly `MEM_LAT` cycles after the grant.
- Read throughput: one read every `MEM_LAT` cycles.
- Store throughput: one store per cycle.
- Simultaneous requests at the rvalid cycle: arbitrated exactly as in IDLE.
- A request arriving while the FSM is in WAIT (not its final cycle) waits. Its gnt is 0.

## Test plan
- Reset: `rst` = 1 for 2 cycles with both requests high -> all outputs 0, no `ram_en`. Release -> `mem_gnt` in the first cycle after release.
- Single IF read, `MEM_LAT` = 2: `if_addr` = 0x10, RAM returns 0xDEADBEEF -> `if_gnt` at t, `if_rvalid` with 0xDEADBEEF at t+2, `mem_rvalid` stays 0.
- Back-to-back stores: `mem_we` = 1 held for 3 cycles, addresses 0x20/0x24/0x28 -> `mem_gnt` and `ram_we` = 1 on 3 consecutive cycles with matching addresses, `busy` = 0 throughout.
- Starvation, `STARVE_MAX` = 4: `if_req` held high, MEM issues back-to-back loads -> MEM wins 4 arbitrations, the 5th goes to IF, then `starve_cnt` = 0.
- Priority plus back-to-back: both requests active at the rvalid cycle of a MEM load -> `mem_rvalid` and the new `mem_gnt` occur in the same cycle; IF stays pending.
- Reset mid-read: assert `rst` at t+1 after an IF read grant -> no `if_rvalid` at t+2, `busy` = 0 from t+2.
